// File: rtl/exec_unit_pkg.sv
// rtl/exec_unit_pkg.sv - opcode and FSM encodings plus datapath defaults for exec_unit
package exec_unit_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int AW_DEF    = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_WB   = 2'b11
  } state_e;

endpackage

// File: rtl/exec_unit_if.sv
// rtl/exec_unit_if.sv - issue/writeback bundle between issue logic, exec_unit and regfile
interface exec_unit_if
  import exec_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
);
  logic             start;
  op_e              op;
  logic [AW-1:0]    dst;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             write_en;
  logic [AW-1:0]    wreg;
  logic [WIDTH-1:0] writedata;
  logic             zero;
  logic             carry;

  modport master (
    output start, op, dst, src_a, src_b,
    input  busy, done, write_en, wreg, writedata, zero, carry
  );

  modport slave (
    input  start, op, dst, src_a, src_b,
    output busy, done, write_en, wreg, writedata, zero, carry
  );
endinterface

// File: rtl/exec_unit_alu_comb.sv
// rtl/exec_unit_alu_comb.sv - combinational result and carry for the seven single-cycle ops
module alu_comb
  import exec_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);
  logic [WIDTH:0] wide;
  logic [3:0]     amt;

  assign amt = b_i[3:0];

  // One spare bit catches carry/borrow, or the last bit shifted out of either end.
  always_comb begin
    wide     = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        wide     = {1'b0, a_i} + {1'b0, b_i};
        result_o = wide[WIDTH-1:0];
        carry_o  = wide[WIDTH];
      end
      OP_SUB: begin
        wide     = {1'b0, a_i} - {1'b0, b_i};
        result_o = wide[WIDTH-1:0];
        carry_o  = wide[WIDTH];
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_SHL: begin
        wide     = {1'b0, a_i} << amt;
        result_o = wide[WIDTH-1:0];
        carry_o  = wide[WIDTH];
      end
      OP_SHR: begin
        wide     = {a_i, 1'b0} >> amt;
        result_o = wide[WIDTH:1];
        carry_o  = wide[0];
      end
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute/writeback stage: operand latch, ALU/shift-add multiply, one-cycle regfile write
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input logic        clk,
  input logic        rst,
  exec_unit_if.slave bus
);
  state_e           state_q;
  op_e              op_q;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [3:0]       count_q;
  logic             we_q, zero_q, carry_q;
  logic [AW-1:0]    wreg_q;
  logic [WIDTH-1:0] wdata_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH-1:0] acc_d;

  alu_comb #(.WIDTH(WIDTH)) u_alu (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res),
    .carry_o  (alu_carry)
  );

  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            dst_q   <= bus.dst;
            a_q     <= bus.src_a;
            b_q     <= bus.src_b;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_MUL) begin
            acc_q    <= '0;
            count_q  <= '0;
            mcand_q  <= a_q;
            mplier_q <= b_q;
            state_q  <= ST_MUL;
          end else begin
            we_q    <= 1'b1;
            wreg_q  <= dst_q;
            wdata_q <= alu_res;
            zero_q  <= (alu_res == '0);
            carry_q <= alu_carry;
            state_q <= ST_WB;
          end
        end
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 4'd1;
          // The 16th iteration's partial sum goes straight to the write port.
          if (count_q == 4'd15) begin
            we_q    <= 1'b1;
            wreg_q  <= dst_q;
            wdata_q <= acc_d;
            zero_q  <= (acc_d == '0);
            carry_q <= 1'b0;
            state_q <= ST_WB;
          end
        end
        ST_WB:   state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = we_q;
  assign bus.write_en  = we_q;
  assign bus.wreg      = wreg_q;
  assign bus.writedata = wdata_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
endmodule
